// File: rtl/reset_conditioner.sv
// reset_conditioner
//   Turns the raw active-low board button into two outputs in the clk_i domain:
//   a clean active-low reset for downstream logic and a one-cycle press event.
//   The button passes through a 2-flop synchroniser and a counter debouncer.
//   A small FSM then holds the reset low for a stretch period after reset
//   release and after each button release.
//
//   Optional feature macro: LONG_PRESS_EN
//     defined   - a press asserts reset only after LongPressCycles of debounced
//                 hold; short presses only pulse press_o (adds HELD + lp_cnt)
//     undefined - every debounced press drops rst_no on the following cycle
//
// Parameters
//   DebounceCycles   cycles btn must be stable before it registers
//   StretchCycles    cycles rst_no is held low after reset / button release
//   LongPressCycles  debounced hold time that triggers reset (LONG_PRESS_EN)
//
// Ports
//   clk_i    in  system clock
//   rst_i    in  synchronous active-high reset
//   btn_ni   in  raw button, active-low, asynchronous to clk_i
//   rst_no   out conditioned active-low reset, registered
//   press_o  out one-cycle pulse on each debounced press (btn_db 1->0)
module reset_conditioner #(
  parameter int unsigned DebounceCycles  = 500_000,
  parameter int unsigned StretchCycles   = 1024,
  parameter int unsigned LongPressCycles = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_ni,
  output logic rst_no,
  output logic press_o
);

  if (DebounceCycles == 0 || StretchCycles == 0 || LongPressCycles == 0) begin : g_param_check
    $error("reset_conditioner: cycle count parameters must be nonzero");
  end

  localparam int unsigned DW = $clog2(DebounceCycles + 1);
  localparam int unsigned SW = $clog2(StretchCycles + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DebounceCycles - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(StretchCycles - 1);

`ifdef LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LongPressCycles + 1);
  localparam logic [LW-1:0] LP_LAST  = LW'(LongPressCycles - 1);
  // The cycle that enters HELD already sees btn_db low, so it counts as one.
  localparam logic [LW-1:0] LP_FIRST = (LongPressCycles > 1) ? LW'(1) : '0;

  typedef enum logic [2:0] {
    STRETCH = 3'b001,
    RUN     = 3'b010,
    HELD    = 3'b100
  } state_e;

  logic [LW-1:0] lp_cnt_q, lp_cnt_d;
`else
  typedef enum logic [1:0] {
    STRETCH = 2'b01,
    RUN     = 2'b10
  } state_e;
`endif

  state_e        state_q, state_d;
  logic          s1_q, s1_d;
  logic          sync_q, sync_d;
  logic          db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [SW-1:0] st_cnt_q, st_cnt_d;
  logic          rst_n_q, rst_n_d;
  logic          press_q, press_d;

  always_comb begin
    s1_d     = btn_ni;
    sync_d   = s1_q;
    db_d     = db_q;
    db_cnt_d = '0;
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
`ifdef LONG_PRESS_EN
    lp_cnt_d = lp_cnt_q;
`endif

    // Debounce: the terminal compare doubles as the saturation limit.
    if (sync_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    press_d = db_q & ~db_d;

    case (state_q)
      STRETCH: begin
        // Advance only when btn_db is high both before and after this cycle's
        // debounce update, so a press landing on terminal count keeps STRETCH.
        if (!(db_q && db_d)) begin
          st_cnt_d = '0;
        end else if (st_cnt_q == ST_LAST) begin
          st_cnt_d = '0;
          state_d  = RUN;
        end else begin
          st_cnt_d = st_cnt_q + 1'b1;
        end
      end
      RUN: begin
        // press_q marks the btn_db falling edge of the previous cycle.
        if (press_q) begin
`ifdef LONG_PRESS_EN
          state_d  = HELD;
          lp_cnt_d = LP_FIRST;
`else
          state_d  = STRETCH;
          st_cnt_d = '0;
`endif
        end
      end
`ifdef LONG_PRESS_EN
      HELD: begin
        if (db_q) begin
          state_d  = RUN;
          lp_cnt_d = '0;
        end else if (lp_cnt_q == LP_LAST) begin
          state_d  = STRETCH;
          st_cnt_d = '0;
          lp_cnt_d = '0;
        end else begin
          lp_cnt_d = lp_cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d  = STRETCH;
        st_cnt_d = '0;
      end
    endcase

    rst_n_d = (state_d != STRETCH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= 1'b1;
      sync_q   <= 1'b1;
      db_q     <= 1'b1;
      db_cnt_q <= '0;
      st_cnt_q <= '0;
      state_q  <= STRETCH;
      rst_n_q  <= 1'b0;
      press_q  <= 1'b0;
`ifdef LONG_PRESS_EN
      lp_cnt_q <= '0;
`endif
    end else begin
      s1_q     <= s1_d;
      sync_q   <= sync_d;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      st_cnt_q <= st_cnt_d;
      state_q  <= state_d;
      rst_n_q  <= rst_n_d;
      press_q  <= press_d;
`ifdef LONG_PRESS_EN
      lp_cnt_q <= lp_cnt_d;
`endif
    end
  end

  assign rst_no  = rst_n_q;
  assign press_o = press_q;

endmodule
